// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: word-addressed data memory with a synchronous store port
// and a combinational read port, followed by the MEM/WB latch and writeback decode.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_instr,
    input  logic [31:0] M_ALUout,
    input  logic [31:0] M_data_rt,
    input  logic [31:0] M_RegWD,
    output logic [31:0] M_RDdata,
    output logic [31:0] W_PC,
    output logic [31:0] W_instr,
    output logic [31:0] W_RegWD,
    output logic [4:0]  W_RegAddr,
    output logic        W_RegWE
);

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RW    = 5;
    localparam int unsigned OPW   = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] FN_ADD   = 6'b100000;
    localparam logic [OPW-1:0] FN_SUB   = 6'b100010;
    localparam logic [RW-1:0]  REG_RA   = 5'd31;

    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  word_idx;
    logic           store_en;

    logic [DW-1:0]  pc_q;
    logic [DW-1:0]  instr_q;
    logic [DW-1:0]  alu_q;
    logic [DW-1:0]  rddata_q;
    logic [DW-1:0]  regwd_q;

    logic [OPW-1:0] opcode_q;
    logic [OPW-1:0] funct_q;
    logic [RW-1:0]  dest;

    // Byte address bits [1:0] and [31:12] are dropped, so the memory aliases every 4 KiB.
    assign word_idx = M_ALUout[AW+1:2];
    assign store_en = (M_instr[31:26] == OP_SW);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            mem[word_idx] <= M_data_rt;
        end
    end

    assign M_RDdata = mem[word_idx];

    // MEM/WB latch: free-running, no stall or enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            instr_q  <= '0;
            alu_q    <= '0;
            rddata_q <= '0;
            regwd_q  <= '0;
        end else begin
            pc_q     <= M_PC;
            instr_q  <= M_instr;
            alu_q    <= M_ALUout;
            rddata_q <= M_RDdata;
            regwd_q  <= M_RegWD;
        end
    end

    assign opcode_q = instr_q[31:26];
    assign funct_q  = instr_q[5:0];

    always_comb begin
        dest = '0;
        case (opcode_q)
            OP_RTYPE: begin
                if ((funct_q == FN_ADD) || (funct_q == FN_SUB)) begin
                    dest = instr_q[15:11];
                end
            end
            OP_ORI, OP_LW, OP_LUI: dest = instr_q[20:16];
            OP_JAL:                dest = REG_RA;
            default:               dest = '0;
        endcase
    end

    assign W_PC      = pc_q;
    assign W_instr   = instr_q;
    assign W_RegWD   = (opcode_q == OP_LW) ? rddata_q : regwd_q;
    assign W_RegAddr = dest;
    assign W_RegWE   = (dest != '0);

    // Latched address and ignored address bits are kept only for observability.
    logic unused_bits;
    assign unused_bits = ^{alu_q, M_ALUout[31:12], M_ALUout[1:0]};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference memory and writeback decode predict
// each W-stage result at issue time; results are popped and compared one cycle later.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC, M_instr, M_ALUout, M_data_rt, M_RegWD;
    logic [31:0] M_RDdata, W_PC, W_instr, W_RegWD;
    logic [4:0]  W_RegAddr;
    logic        W_RegWE;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
        logic [4:0]  addr;
        logic        we;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [1024];
    int          checks = 0;
    int          errors = 0;

    mem_wb_stage dut (
        .clk       (clk),
        .reset     (reset),
        .M_PC      (M_PC),
        .M_instr   (M_instr),
        .M_ALUout  (M_ALUout),
        .M_data_rt (M_data_rt),
        .M_RegWD   (M_RegWD),
        .M_RDdata  (M_RDdata),
        .W_PC      (W_PC),
        .W_instr   (W_instr),
        .W_RegWD   (W_RegWD),
        .W_RegAddr (W_RegAddr),
        .W_RegWE   (W_RegWE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Reference writeback destination.
    function automatic logic [4:0] ref_dest(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) return ins[15:11];
        if (op == 6'h0d || op == 6'h23 || op == 6'h0f)   return ins[20:16];
        if (op == 6'h03)                                 return 5'd31;
        return 5'd0;
    endfunction

    task automatic compare_w();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("W_PC",      W_PC,             e.pc);
            check("W_instr",   W_instr,          e.instr);
            check("W_RegWD",   W_RegWD,          e.wd);
            check("W_RegAddr", 32'(W_RegAddr),   32'(e.addr));
            check("W_RegWE",   32'(W_RegWE),     32'(e.we));
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                         input logic [31:0] data, input logic [31:0] regwd);
        M_PC      = pc;
        M_instr   = instr;
        M_ALUout  = alu;
        M_data_rt = data;
        M_RegWD   = regwd;
    endtask

    // One normal cycle: predict, push, clock, then compare the W stage.
    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                        input logic [31:0] data, input logic [31:0] regwd);
        exp_t        e;
        logic [9:0]  idx;
        logic [31:0] rd;
        drive(pc, instr, alu, data, regwd);
        #1;
        idx = alu[11:2];
        rd  = model_mem[idx];
        check("M_RDdata", M_RDdata, rd);
        e.pc    = pc;
        e.instr = instr;
        e.addr  = ref_dest(instr);
        e.we    = (e.addr != 5'd0);
        e.wd    = (instr[31:26] == 6'h23) ? rd : regwd;
        sb.push_back(e);
        if (instr[31:26] == 6'h2b) model_mem[idx] = data;
        @(posedge clk);
        #1;
        compare_w();
    endtask

    // One reset cycle with arbitrary stimulus presented; everything must read as zero after.
    task automatic reset_step(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                              input logic [31:0] data, input logic [31:0] regwd);
        exp_t e;
        reset = 1'b1;
        drive(pc, instr, alu, data, regwd);
        e.pc = '0; e.instr = '0; e.wd = '0; e.addr = '0; e.we = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_w();
    endtask

    initial begin
        reset = 1'b1;
        drive('0, '0, '0, '0, '0);

        reset_step(32'h0000_3000, itype(6'h2b, 5'd0, 5'd9, 16'h0010), 32'h0000_0010,
                   32'h5555_5555, 32'h7777_7777);

        // Store then load at the same word.
        step(32'h0000_3004, itype(6'h2b, 5'd0, 5'd9, 16'h0010), 32'h0000_0010, 32'h1234_5678, 32'h0);
        step(32'h0000_3008, itype(6'h23, 5'd0, 5'd8, 16'h0010), 32'h0000_0010, 32'h0, 32'h0);
        check("lw_after_sw_wd",   W_RegWD,           32'h1234_5678);
        check("lw_after_sw_addr", 32'(W_RegAddr),    32'd8);
        check("lw_after_sw_we",   32'(W_RegWE),      32'd1);

        // Address wrap modulo 4 KiB and ignored low bits.
        step(32'h0000_300C, itype(6'h2b, 5'd0, 5'd2, 16'h1004), 32'h0000_1004, 32'hCAFE_F00D, 32'h0);
        step(32'h0000_3010, itype(6'h23, 5'd0, 5'd3, 16'h0004), 32'h0000_0004, 32'h0, 32'h0);
        check("wrap_lw_wd", W_RegWD, 32'hCAFE_F00D);
        step(32'h0000_3014, itype(6'h23, 5'd0, 5'd4, 16'h0007), 32'h0000_0007, 32'h0, 32'h0);
        check("lowbits_lw_wd", W_RegWD, 32'hCAFE_F00D);

        // Non-load writeback.
        step(32'h0000_3018, rtype(5'd1, 5'd2, 5'd5, 6'h20), 32'h0, 32'h0, 32'h0000_00FF);
        check("add_wd",   W_RegWD,        32'h0000_00FF);
        check("add_addr", 32'(W_RegAddr), 32'd5);
        check("add_we",   32'(W_RegWE),   32'd1);
        step(32'h0000_301C, jtype(6'h03, 26'h0000C03), 32'h0, 32'h0, 32'h0000_300C);
        check("jal_addr", 32'(W_RegAddr), 32'd31);
        check("jal_wd",   W_RegWD,        32'h0000_300C);
        step(32'h0000_3020, rtype(5'd3, 5'd4, 5'd7, 6'h22), 32'h0, 32'h0, 32'hFFFF_FFFE);
        step(32'h0000_3024, itype(6'h0d, 5'd1, 5'd6, 16'h00F0), 32'h0, 32'h0, 32'h0000_00F1);
        step(32'h0000_3028, itype(6'h0f, 5'd0, 5'd9, 16'hABCD), 32'h0, 32'h0, 32'hABCD_0000);

        // No-write cases.
        step(32'h0000_302C, 32'h0, 32'h0, 32'h0, 32'h1111_2222);
        check("nop_we", 32'(W_RegWE), 32'd0);
        step(32'h0000_3030, itype(6'h2b, 5'd0, 5'd7, 16'h0100), 32'h0000_0100, 32'h0BAD_0BAD, 32'h3);
        step(32'h0000_3034, itype(6'h04, 5'd1, 5'd2, 16'h0004), 32'h0, 32'h0, 32'h4);
        step(32'h0000_3038, rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h0, 32'h0, 32'h5);
        step(32'h0000_303C, itype(6'h0d, 5'd1, 5'd0, 16'h0001), 32'h0, 32'h0, 32'h6);
        check("ori_r0_we",   32'(W_RegWE),   32'd0);
        check("ori_r0_addr", 32'(W_RegAddr), 32'd0);

        // Reset mid-stream while a store is presented.
        step(32'h0000_3040, itype(6'h2b, 5'd0, 5'd1, 16'h0020), 32'h0000_0020, 32'hDEAD_BEEF, 32'h0);
        reset_step(32'h0000_3044, itype(6'h2b, 5'd0, 5'd1, 16'h0020), 32'h0000_0020,
                   32'h1111_1111, 32'h9999_9999);
        check("rst_mid_pc", W_PC, 32'h0);
        step(32'h0000_3048, itype(6'h23, 5'd0, 5'd10, 16'h0020), 32'h0000_0020, 32'h0, 32'h0);
        check("rst_lw_wd", W_RegWD, 32'h0);

        // Back-to-back stores to the same word: the later one wins.
        step(32'h0000_304C, itype(6'h2b, 5'd0, 5'd1, 16'h0040), 32'h0000_0040, 32'h0000_000A, 32'h0);
        step(32'h0000_3050, itype(6'h2b, 5'd0, 5'd1, 16'h0040), 32'h0000_0040, 32'h0000_000B, 32'h0);
        step(32'h0000_3054, itype(6'h23, 5'd0, 5'd12, 16'h0040), 32'h0000_0040, 32'h0, 32'h0);
        check("b2b_sw_wd", W_RegWD, 32'h0000_000B);

        // Random mix over a small, aliased address window.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] ins;
            logic [31:0] alu;
            logic [4:0]  ra, rb, rc;
            ra  = 5'($urandom);
            rb  = 5'($urandom);
            rc  = 5'($urandom);
            alu = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: ins = rtype(ra, rb, rc, 6'h20);
                1: ins = rtype(ra, rb, rc, 6'h22);
                2: ins = itype(6'h0d, ra, rb, 16'($urandom));
                3: ins = itype(6'h23, ra, rb, 16'($urandom));
                4: ins = itype(6'h23, ra, rb, 16'($urandom));
                5: ins = itype(6'h0f, ra, rb, 16'($urandom));
                6: ins = jtype(6'h03, 26'($urandom));
                7: ins = itype(6'h2b, ra, rb, 16'($urandom));
                8: ins = itype(6'h2b, ra, rb, 16'($urandom));
                default: ins = rtype(ra, rb, rc, 6'h08);
            endcase
            step(32'h0000_4000 + 32'(n * 4), ins, alu, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
